// File: rtl/milano_pkg.sv
// Shared types for the milano core: ALU operation encoding, the ID->EX
// payload and register-file constants.
package milano_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_opt_e;

  typedef struct packed {
    alu_opt_e    operate;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
  } id_ex_pkt_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Per-operand forwarding mux: x0 forces zero, then the EX result (youngest),
// then the writeback result, then the register file.
module operand_fwd
  import milano_pkg::*;
(
  input  logic [4:0]  rs_addr,
  input  logic [31:0] rf_data,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] data
);

  // priority select of the operand source
  always_comb begin
    data = 32'd0;
    if (rs_addr == REG_ZERO) begin
      data = 32'd0;
    end else if (ex_we && (ex_waddr == rs_addr)) begin
      data = ex_wdata;
    end else if (wb_we && (wb_waddr == rs_addr)) begin
      data = wb_wdata;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register of the milano core: valid/ready capture with
// operand forwarding, flush, backpressure hold and a saturating stall counter.
module id_ex_stage
  import milano_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   id_valid_i,
  output logic                   id_ready_o,
  input  alu_opt_e               id_operate_i,
  input  logic [4:0]             id_rs1_addr_i,
  input  logic [4:0]             id_rs2_addr_i,
  input  logic [31:0]            id_rs1_data_i,
  input  logic [31:0]            id_rs2_data_i,
  input  logic [31:0]            id_imm_i,
  input  logic                   id_use_imm_i,
  input  logic [4:0]             id_rd_addr_i,
  input  logic                   id_rd_we_i,
  input  logic                   alu_rd_we_i,
  input  logic [4:0]             alu_rd_waddr_i,
  input  logic [31:0]            alu_rd_wdata_i,
  input  logic                   wb_rd_we_i,
  input  logic [4:0]             wb_rd_waddr_i,
  input  logic [31:0]            wb_rd_wdata_i,
  input  logic                   ex_ready_i,
  output logic                   ex_valid_o,
  output alu_opt_e               ex_operate_o,
  output logic [31:0]            ex_operand_a_o,
  output logic [31:0]            ex_operand_b_o,
  output logic [4:0]             ex_rd_addr_o,
  output logic                   ex_rd_we_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  id_ex_pkt_t             ex_pkt_r;
  logic                   ex_valid_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;
  logic [31:0]            fwd_rs1_s;
  logic [31:0]            fwd_rs2_s;
  logic                   ex_fwd_en_s;
  logic                   accept_s;
  logic                   stall_s;
  id_ex_pkt_t             next_pkt_s;

  // EX feedback is only meaningful while EX actually holds an instruction
  assign ex_fwd_en_s = ex_valid_r & alu_rd_we_i;
  assign id_ready_o  = flush_i | ~ex_valid_r | ex_ready_i;
  assign accept_s    = id_valid_i & id_ready_o;
  assign stall_s     = ex_valid_r & ~ex_ready_i & ~flush_i;

  operand_fwd u_fwd_rs1 (
    .rs_addr  (id_rs1_addr_i),
    .rf_data  (id_rs1_data_i),
    .ex_we    (ex_fwd_en_s),
    .ex_waddr (alu_rd_waddr_i),
    .ex_wdata (alu_rd_wdata_i),
    .wb_we    (wb_rd_we_i),
    .wb_waddr (wb_rd_waddr_i),
    .wb_wdata (wb_rd_wdata_i),
    .data     (fwd_rs1_s)
  );

  operand_fwd u_fwd_rs2 (
    .rs_addr  (id_rs2_addr_i),
    .rf_data  (id_rs2_data_i),
    .ex_we    (ex_fwd_en_s),
    .ex_waddr (alu_rd_waddr_i),
    .ex_wdata (alu_rd_wdata_i),
    .wb_we    (wb_rd_we_i),
    .wb_waddr (wb_rd_waddr_i),
    .wb_wdata (wb_rd_wdata_i),
    .data     (fwd_rs2_s)
  );

  // assemble the payload captured on accept
  always_comb begin
    next_pkt_s           = '0;
    next_pkt_s.operate   = id_operate_i;
    next_pkt_s.operand_a = fwd_rs1_s;
    if (id_use_imm_i) begin
      next_pkt_s.operand_b = id_imm_i;
    end else begin
      next_pkt_s.operand_b = fwd_rs2_s;
    end
    next_pkt_s.rd_addr   = id_rd_addr_i;
    next_pkt_s.rd_we     = id_rd_we_i;
  end

  // pipeline register: flush > accept > drain > hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_r       <= 1'b0;
      ex_pkt_r         <= '0;
      ex_pkt_r.operate <= ALU_ADD;
    end else if (flush_i) begin
      ex_valid_r <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
      ex_pkt_r   <= next_pkt_s;
    end else if (ex_ready_i) begin
      ex_valid_r <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // saturating backpressure counter, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= '0;
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign ex_valid_o     = ex_valid_r;
  assign ex_operate_o   = ex_pkt_r.operate;
  assign ex_operand_a_o = ex_pkt_r.operand_a;
  assign ex_operand_b_o = ex_pkt_r.operand_b;
  assign ex_rd_addr_o   = ex_pkt_r.rd_addr;
  assign ex_rd_we_o     = ex_pkt_r.rd_we & ex_valid_r;
  assign stall_cnt_o    = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, backpressure, flush, immediate
// select and stall-counter saturation (counter built 4 bits wide).
module tb_id_ex_stage;
  import milano_pkg::*;

  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, id_valid_i, id_ready_o;
  alu_opt_e      id_operate_i;
  logic [4:0]    id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic [31:0]   id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic          id_use_imm_i, id_rd_we_i;
  logic          alu_rd_we_i, wb_rd_we_i, ex_ready_i;
  logic [4:0]    alu_rd_waddr_i, wb_rd_waddr_i;
  logic [31:0]   alu_rd_wdata_i, wb_rd_wdata_i;
  logic          ex_valid_o, ex_rd_we_o;
  alu_opt_e      ex_operate_o;
  logic [31:0]   ex_operand_a_o, ex_operand_b_o;
  logic [4:0]    ex_rd_addr_o;
  logic [CW-1:0] stall_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.STALL_CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_operate_i(id_operate_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_use_imm_i(id_use_imm_i),
    .id_rd_addr_i(id_rd_addr_i), .id_rd_we_i(id_rd_we_i),
    .alu_rd_we_i(alu_rd_we_i), .alu_rd_waddr_i(alu_rd_waddr_i),
    .alu_rd_wdata_i(alu_rd_wdata_i),
    .wb_rd_we_i(wb_rd_we_i), .wb_rd_waddr_i(wb_rd_waddr_i),
    .wb_rd_wdata_i(wb_rd_wdata_i),
    .ex_ready_i(ex_ready_i), .ex_valid_o(ex_valid_o),
    .ex_operate_o(ex_operate_o), .ex_operand_a_o(ex_operand_a_o),
    .ex_operand_b_o(ex_operand_b_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_rd_we_o(ex_rd_we_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input alu_opt_e op, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [4:0] rd);
    id_valid_i    = 1'b1;
    id_operate_i  = op;
    id_rs1_addr_i = rs1;
    id_rs1_data_i = d1;
    id_rs2_addr_i = rs2;
    id_rs2_data_i = d2;
    id_rd_addr_i  = rd;
    id_rd_we_i    = 1'b1;
    id_use_imm_i  = 1'b0;
    id_imm_i      = 32'd0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, ex_valid_o}, 32'd0);
    check({tag, "_op"}, {28'd0, ex_operate_o}, {28'd0, ALU_ADD});
    check({tag, "_a"}, ex_operand_a_o, 32'd0);
    check({tag, "_b"}, ex_operand_b_o, 32'd0);
    check({tag, "_rd"}, {27'd0, ex_rd_addr_o}, 32'd0);
    check({tag, "_we"}, {31'd0, ex_rd_we_o}, 32'd0);
    check({tag, "_cnt"}, {28'd0, stall_cnt_o}, 32'd0);
    check({tag, "_ready"}, {31'd0, id_ready_o}, 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b1;
    issue(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0);
    id_valid_i = 1'b0; id_rd_we_i = 1'b0;
    alu_rd_we_i = 1'b0; alu_rd_waddr_i = 5'd0; alu_rd_wdata_i = 32'd0;
    wb_rd_we_i = 1'b0; wb_rd_waddr_i = 5'd0; wb_rd_wdata_i = 32'd0;
    step(); step();
    rst_i = 1'b0;
    #1;
    check_idle("reset");

    // EX forward beats a simultaneous WB write to the same register
    issue(ALU_ADD, 5'd1, 32'd3, 5'd2, 32'd4, 5'd5);
    step();
    check("add_valid", {31'd0, ex_valid_o}, 32'd1);
    check("add_a", ex_operand_a_o, 32'd3);
    check("add_b", ex_operand_b_o, 32'd4);
    check("add_rd", {27'd0, ex_rd_addr_o}, 32'd5);
    check("add_we", {31'd0, ex_rd_we_o}, 32'd1);
    alu_rd_we_i = 1'b1; alu_rd_waddr_i = 5'd5; alu_rd_wdata_i = 32'h10;
    wb_rd_we_i = 1'b1; wb_rd_waddr_i = 5'd5; wb_rd_wdata_i = 32'h99;
    issue(ALU_OR, 5'd5, 32'h77, 5'd9, 32'hABCD, 5'd6);
    step();
    check("exfwd_a", ex_operand_a_o, 32'h10);
    check("nofwd_b", ex_operand_b_o, 32'hABCD);
    check("exfwd_op", {28'd0, ex_operate_o}, {28'd0, ALU_OR});

    // WB forward on rs1, x0 on rs2 ignores regfile, WB and EX writes to x0
    alu_rd_we_i = 1'b0;
    wb_rd_waddr_i = 5'd7; wb_rd_wdata_i = 32'hDEAD;
    issue(ALU_AND, 5'd7, 32'h1111, 5'd0, 32'h1234, 5'd8);
    step();
    check("wbfwd_a", ex_operand_a_o, 32'hDEAD);
    check("x0_b", ex_operand_b_o, 32'd0);
    alu_rd_we_i = 1'b1; alu_rd_waddr_i = 5'd0; alu_rd_wdata_i = 32'h66;
    wb_rd_waddr_i = 5'd0; wb_rd_wdata_i = 32'h55;
    issue(ALU_AND, 5'd0, 32'h2222, 5'd0, 32'h1234, 5'd8);
    step();
    check("x0_a_w", ex_operand_a_o, 32'd0);
    check("x0_b_w", ex_operand_b_o, 32'd0);
    alu_rd_we_i = 1'b0; wb_rd_we_i = 1'b0;

    // backpressure: hold SUB for three cycles while decode keeps offering
    issue(ALU_SUB, 5'd1, 32'h100, 5'd2, 32'h20, 5'd3);
    step();
    check("sub_op", {28'd0, ex_operate_o}, {28'd0, ALU_SUB});
    ex_ready_i = 1'b0;
    issue(ALU_XOR, 5'd10, 32'h5A5A, 5'd11, 32'h0F0F, 5'd4);
    wb_rd_we_i = 1'b1; wb_rd_waddr_i = 5'd1; wb_rd_wdata_i = 32'hBAD;
    #1;
    check("bp_ready", {31'd0, id_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_op", {28'd0, ex_operate_o}, {28'd0, ALU_SUB});
      check("bp_a", ex_operand_a_o, 32'h100);
      check("bp_b", ex_operand_b_o, 32'h20);
      check("bp_rd", {27'd0, ex_rd_addr_o}, 32'd3);
    end
    check("bp_cnt", {28'd0, stall_cnt_o}, 32'd3);
    wb_rd_we_i = 1'b0;
    ex_ready_i = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, id_ready_o}, 32'd1);
    step();
    check("replace_op", {28'd0, ex_operate_o}, {28'd0, ALU_XOR});
    check("replace_a", ex_operand_a_o, 32'h5A5A);
    check("replace_rd", {27'd0, ex_rd_addr_o}, 32'd4);
    check("replace_cnt", {28'd0, stall_cnt_o}, 32'd3);

    // flush with incoming valid and a stalled downstream
    ex_ready_i = 1'b0; flush_i = 1'b1;
    issue(ALU_SLL, 5'd1, 32'h1, 5'd2, 32'h2, 5'd9);
    #1;
    check("flush_ready", {31'd0, id_ready_o}, 32'd1);
    step();
    check("flush_valid", {31'd0, ex_valid_o}, 32'd0);
    check("flush_we", {31'd0, ex_rd_we_o}, 32'd0);
    check("flush_cnt", {28'd0, stall_cnt_o}, 32'd3);
    flush_i = 1'b0;

    // immediate select, then drain with no new instruction
    issue(ALU_ADD, 5'd1, 32'h8, 5'd2, 32'h5, 5'd12);
    id_use_imm_i = 1'b1; id_imm_i = 32'hFFFFFFFC; ex_ready_i = 1'b1;
    step();
    check("imm_b", ex_operand_b_o, 32'hFFFFFFFC);
    check("imm_a", ex_operand_a_o, 32'h8);
    id_valid_i = 1'b0;
    step();
    check("drain_valid", {31'd0, ex_valid_o}, 32'd0);

    // refill then stall long enough to saturate the 4-bit counter
    issue(ALU_SRA, 5'd1, 32'h80, 5'd2, 32'h1, 5'd13);
    step();
    id_valid_i = 1'b0; ex_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", {28'd0, stall_cnt_o}, 32'hF);
    check("sat_valid", {31'd0, ex_valid_o}, 32'd1);

    // reset mid-stall clears everything
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check_idle("rst_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID->EX pipeline register of the milano core, directly upstream of the ALU; drives its operate/operand/rd inputs.
- Accepts one decoded instruction per cycle over a valid/ready handshake.
- Resolves RAW hazards by forwarding from the ALU output (EX) and the writeback port (WB).
- Selects immediate vs rs2; supports flush and downstream backpressure.
- Keeps a saturating backpressure-stall counter.

Parameters:
STALL_CNT_W, 16, width of stall_cnt_o

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  kill held instruction and discard incoming
id_valid_i  in  1  decode has an instruction
id_ready_o  out  1  stage accepts this cycle
id_operate_i  in  alu_opt_e  ALU operation
id_rs1_addr_i  in  5  rs1 index
id_rs2_addr_i  in  5  rs2 index
id_rs1_data_i  in  32  regfile rs1 value
id_rs2_data_i  in  32  regfile rs2 value
id_imm_i  in  32  sign-extended immediate
id_use_imm_i  in  1  1: operand_b = imm
id_rd_addr_i  in  5  destination index
id_rd_we_i  in  1  destination write enable
alu_rd_we_i  in  1  ALU result write enable (EX feedback)
alu_rd_waddr_i  in  5  ALU result rd
alu_rd_wdata_i  in  32  ALU result data
wb_rd_we_i  in  1  writeback write enable
wb_rd_waddr_i  in  5  writeback rd
wb_rd_wdata_i  in  32  writeback data
ex_ready_i  in  1  ALU/next stage consumes this cycle
ex_valid_o  out  1  EX holds a valid instruction
ex_operate_o  out  alu_opt_e  to ALU operate_i
ex_operand_a_o  out  32  to ALU operand_a_i
ex_operand_b_o  out  32  to ALU operand_b_i
ex_rd_addr_o  out  5  to ALU rd_addr_i
ex_rd_we_o  out  1  to ALU rd_we_i, gated by ex_valid_o
stall_cnt_o  out  STALL_CNT_W  saturating count of backpressure cycles

Behaviour:
- Reset (rst_i=1 at edge): ex_valid_o=0, ex_operate_o=ALU_ADD, operands=0, ex_rd_addr_o=0, ex_rd_we_o=0, stall_cnt_o=0. Reset wins over every other event, including mid-stall.
- Ready: id_ready_o = flush_i | ~ex_valid_o | ex_ready_i. This is combinational.
- Next-state priority, one per edge:
  - flush_i: ex_valid<=0, incoming discarded, upstream sees it as accepted.
  - else id_valid_i & id_ready_o: capture, ex_valid<=1.
  - else ex_ready_i: ex_valid<=0.
  - else hold all registers.
- Latency: 1 cycle from accept to ex_*_o. Back-to-back accept with ex_ready_i=1 gives full throughput.
- Forwarding, per source operand, evaluated combinationally in the accept cycle:
  - Address 0 always yields 0, never forwarded, ignoring regfile data.
  - EX match: ex_valid_o & alu_rd_we_i & alu_rd_waddr_i==rsN. Highest priority (youngest).
  - WB match: wb_rd_we_i & wb_rd_waddr_i==rsN.
  - Otherwise use the regfile value. The regfile is write-before-read for WB writes.
- Operands: operand_a = fwd rs1; operand_b = id_use_imm_i ? id_imm_i : fwd rs2. Full 32 bits are passed; the ALU masks shift amounts.
- Held instructions keep operands resolved at capture; no re-forwarding while in EX.
- ex_rd_we_o = ex_rd_we_q & ex_valid_q. Bubbles never write.
- stall_cnt_o += 1 on each cycle with ex_valid_o & ~ex_ready_i & ~flush_i. It holds at all-ones (no wrap) and is cleared only by reset.
- Simultaneous flush and ex_ready_i: flush dominates; EX is empty next cycle.
- Simultaneous ex_ready_i and accept: the new instruction replaces the old in the same edge.

Decomposition:
- milano_pkg:
  - reuses alu_opt_e.
  - adds id_ex_pkt_t packed struct {operate, operand_a, operand_b, rd_addr, rd_we}.
  - adds constant REG_ZERO=5'd0.
- Sub-module operand_fwd: a combinational 3-way priority mux, instantiated twice (rs1, rs2).
- Register and control in id_ex_stage.

Test Plan:
1. Reset mid-stall: ex_valid_o=1, ex_ready_i=0, assert rst_i one cycle -> next cycle all outputs 0, stall_cnt_o=0, id_ready_o=1.
2. EX forward: ADD x5 in EX producing alu_rd_wdata_i=0x10, ID issues rs1=x5 while WB writes x5=0x99 -> ex_operand_a_o=0x10 next cycle.
3. WB forward plus x0: rs1=x7 with WB x7=0xDEAD, rs2=x0 with regfile 0x1234 and WB x0=0x55 -> operand_a=0xDEAD, operand_b=0.
4. Backpressure: accept SUB, then ex_ready_i=0 for 3 cycles with id_valid_i=1 -> id_ready_o=0, outputs stable, stall_cnt_o=3. Then ex_ready_i=1 -> next instruction captured the same edge.
5. Flush: ex_valid_o=1, flush_i=1 with id_valid_i=1 -> id_ready_o=1, next cycle ex_valid_o=0, ex_rd_we_o=0.
6. Immediate/saturation:
   - id_use_imm_i=1, imm=0xFFFFFFFC -> operand_b=0xFFFFFFFC.
   - With STALL_CNT_W=4, 20 stall cycles -> stall_cnt_o=0xF.
